// File: rtl/debug_ocimem_sequencer_if.sv
// debug_ocimem_sequencer_if: CPU Avalon debug-slave port bundle shared with the ocimem sequencer
//   cpu_req/cpu_we/cpu_addr/cpu_wdata : request from the CPU (held until cpu_waitrequest=0)
//   cpu_rdata/cpu_waitrequest         : read data and handshake back to the CPU
//   modport master = CPU side, modport slave = sequencer side
interface debug_ocimem_sequencer_if #(parameter int ADDR_W = 8);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_waitrequest;
    modport master (output cpu_req, cpu_we, cpu_addr, cpu_wdata, input cpu_rdata, cpu_waitrequest);
    modport slave  (input cpu_req, cpu_we, cpu_addr, cpu_wdata, output cpu_rdata, cpu_waitrequest);
endinterface

// File: rtl/debug_ocimem_sequencer.sv
// debug_ocimem_sequencer: sequences JTAG debug commands and CPU debug-slave accesses onto one single-port ocimem RAM
//   clk, reset (async, active high)
//   jdo + take_action_ocimem_a / take_no_action_ocimem_a / take_action_ocimem_b : JTAG load / read / write pulses
//   cpu (debug_ocimem_sequencer_if.slave) : CPU Avalon debug-slave port
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata : single-port RAM, read data valid the cycle after ram_en
//   MonDReg/monitor_ready/monitor_error : JTAG read data and status
//   Optional: define DEBUG_OCIMEM_CPU_WP_EN to drop CPU writes into the lower (debug ROM) half
module debug_ocimem_sequencer #(parameter int ADDR_W = 8) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [37:0]           jdo,
    input  logic                  take_action_ocimem_a,
    input  logic                  take_no_action_ocimem_a,
    input  logic                  take_action_ocimem_b,
    debug_ocimem_sequencer_if.slave cpu,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata,
    output logic [31:0]           MonDReg,
    output logic                  monitor_ready,
    output logic                  monitor_error
);
    typedef enum logic [2:0] {IDLE, JOP, JCAP, COP, CCAP} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] jaddr;
    logic              pend_valid, pend_wr;
    logic [31:0]       pend_wdata;
    logic              busy, any_take, multi_take, cpu_wr_ok;
    logic              unused_jdo;

    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};
    assign busy       = pend_valid | (state == JOP) | (state == JCAP);
    assign any_take   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign multi_take = (take_action_ocimem_a & (take_no_action_ocimem_a | take_action_ocimem_b))
                      | (take_no_action_ocimem_a & take_action_ocimem_b);

`ifdef DEBUG_OCIMEM_CPU_WP_EN
    assign cpu_wr_ok = cpu.cpu_addr[ADDR_W-1];
`else
    assign cpu_wr_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_n;

    always_comb begin
        state_n             = state;
        ram_en              = 1'b0;
        ram_we              = 1'b0;
        ram_addr            = '0;
        ram_wdata           = '0;
        cpu.cpu_waitrequest = 1'b1;
        cpu.cpu_rdata       = '0;
        case (state)
            IDLE: state_n = pend_valid ? JOP : (cpu.cpu_req ? COP : IDLE);
            JOP: begin
                ram_en    = 1'b1;
                ram_we    = pend_wr;
                ram_addr  = jaddr;
                ram_wdata = pend_wdata;
                state_n   = pend_wr ? IDLE : JCAP;
            end
            JCAP: state_n = IDLE;
            COP: begin
                ram_en              = 1'b1;
                ram_we              = cpu.cpu_we & cpu_wr_ok;
                ram_addr            = cpu.cpu_addr;
                ram_wdata           = cpu.cpu_wdata;
                cpu.cpu_waitrequest = ~cpu.cpu_we;
                state_n             = cpu.cpu_we ? IDLE : CCAP;
            end
            CCAP: begin
                cpu.cpu_rdata       = ram_rdata;
                cpu.cpu_waitrequest = 1'b0;
                state_n             = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Command intake and JTAG result registers. Pulses arriving while busy (or
    // colliding pulses) flag an overrun; address load outranks read, read outranks write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jaddr         <= '0;
            pend_valid    <= 1'b0;
            pend_wr       <= 1'b0;
            pend_wdata    <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            if (any_take & (busy | multi_take))
                monitor_error <= 1'b1;
            else if (!busy & take_action_ocimem_a & jdo[33])
                monitor_error <= 1'b0;
            if (!busy & take_action_ocimem_a) begin
                jaddr         <= jdo[ADDR_W+16:17];
                pend_valid    <= jdo[34];
                pend_wr       <= 1'b0;
                monitor_ready <= ~jdo[34];
            end else if (!busy & (take_no_action_ocimem_a | take_action_ocimem_b)) begin
                pend_valid    <= 1'b1;
                pend_wr       <= ~take_no_action_ocimem_a;
                pend_wdata    <= jdo[34:3];
                monitor_ready <= 1'b0;
            end
            if (state == JOP) begin
                pend_valid <= 1'b0;
                if (pend_wr) begin
                    jaddr         <= jaddr + ADDR_W'(1);
                    monitor_ready <= 1'b1;
                end
            end
            if (state == JCAP) begin
                MonDReg       <= ram_rdata;
                jaddr         <= jaddr + ADDR_W'(1);
                monitor_ready <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_debug_ocimem_sequencer.sv
// tb_debug_ocimem_sequencer: directed and randomized bench for debug_ocimem_sequencer against a behavioural model
`timescale 1ns/1ps
module tb_debug_ocimem_sequencer;
    localparam int AW = 8;
    localparam int N  = 1 << AW;
`ifdef DEBUG_OCIMEM_CPU_WP_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b0;
    logic [37:0] jdo = '0;
    logic        ta = 1'b0, tr = 1'b0, tw = 1'b0;
    logic        ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata, mon;
    logic        rdy, err;
    int          total = 0, bad = 0;
    bit          last_wait = 1'b1;

    debug_ocimem_sequencer_if #(.ADDR_W(AW)) cpu_bus ();

    debug_ocimem_sequencer #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(ta), .take_no_action_ocimem_a(tr), .take_action_ocimem_b(tw),
        .cpu(cpu_bus),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .MonDReg(mon), .monitor_ready(rdy), .monitor_error(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ival(input int i);
        return (i == 16) ? 32'hDEADBEEF : (32'h1000_0000 | 32'(i));
    endfunction

    // Single-port RAM seen by the DUT; contents survive reset.
    logic [31:0] mem [N];
    bit ram_init = 1'b0;
    always @(posedge clk)
        if (!ram_init) begin
            for (int i = 0; i < N; i++) mem[i] <= ival(i);
            ram_init <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end

    // Behavioural model: who owns the RAM (0 none, 1 JTAG job, 2 CPU job),
    // how far into that job we are, the one queued JTAG command and the status registers.
    function automatic bit wr_ok(input logic [AW-1:0] a);
        return !WP || int'(a) >= N / 2;
    endfunction

    logic [31:0]   rmem [N];
    bit            rm_init = 1'b0;
    int            owner = 0, step = 0;
    bit            q_v = 1'b0, q_wr = 1'b0, c_wr = 1'b0;
    logic [31:0]   q_d = '0, c_d = '0, m_mon = '0;
    logic [AW-1:0] m_jaddr = '0;
    bit            m_rdy = 1'b0, m_err = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            if (!rm_init) begin
                for (int i = 0; i < N; i++) rmem[i] = ival(i);
                rm_init = 1'b1;
            end
            owner = 0; step = 0; q_v = 1'b0;
            m_jaddr = '0; m_mon = '0; m_rdy = 1'b0; m_err = 1'b0;
        end else begin
            bit busy;
            int np;
            busy = q_v || owner == 1;
            np = int'(ta) + int'(tr) + int'(tw);
            if (owner == 0) begin
                if (q_v) begin
                    owner = 1; step = 0; c_wr = q_wr; c_d = q_d; q_v = 1'b0;
                end else if (cpu_bus.cpu_req) begin
                    owner = 2; step = 0;
                end
            end else if (owner == 1) begin
                if (step == 0 && c_wr) begin
                    rmem[m_jaddr] = c_d; m_jaddr++; m_rdy = 1'b1; owner = 0;
                end else if (step == 0) step = 1;
                else begin
                    m_mon = rmem[m_jaddr]; m_jaddr++; m_rdy = 1'b1; owner = 0;
                end
            end else begin
                if (step == 0 && cpu_bus.cpu_we) begin
                    if (wr_ok(cpu_bus.cpu_addr)) rmem[cpu_bus.cpu_addr] = cpu_bus.cpu_wdata;
                    owner = 0;
                end else if (step == 0) step = 1;
                else owner = 0;
            end
            if (np > 0 && (busy || np > 1)) m_err = 1'b1;
            else if (!busy && ta && jdo[33]) m_err = 1'b0;
            if (!busy && ta) begin
                m_jaddr = jdo[AW+16:17];
                if (jdo[34]) begin q_v = 1'b1; q_wr = 1'b0; m_rdy = 1'b0; end
                else m_rdy = 1'b1;
            end else if (!busy && (tr || tw)) begin
                q_v = 1'b1; q_wr = !tr; q_d = jdo[34:3]; m_rdy = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    task automatic compare();
        bit e_en, e_we, e_wait;
        e_en   = owner != 0 && step == 0;
        e_we   = e_en && (owner == 1 ? c_wr : (cpu_bus.cpu_we && wr_ok(cpu_bus.cpu_addr)));
        e_wait = !(owner == 2 && (step == 1 || cpu_bus.cpu_we));
        chk("ram_en", 32'(ram_en), 32'(e_en));
        chk("ram_we", 32'(ram_we), 32'(e_we));
        if (e_en) chk("ram_addr", 32'(ram_addr), 32'(owner == 1 ? m_jaddr : cpu_bus.cpu_addr));
        if (e_we) chk("ram_wdata", ram_wdata, owner == 1 ? c_d : cpu_bus.cpu_wdata);
        chk("cpu_waitrequest", 32'(cpu_bus.cpu_waitrequest), 32'(e_wait));
        if (owner == 2 && step == 1) chk("cpu_rdata", cpu_bus.cpu_rdata, rmem[cpu_bus.cpu_addr]);
        chk("MonDReg", mon, m_mon);
        chk("monitor_ready", 32'(rdy), 32'(m_rdy));
        chk("monitor_error", 32'(err), 32'(m_err));
        last_wait = cpu_bus.cpu_waitrequest;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            compare();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input bit a, input bit r, input bit w, input logic [37:0] d);
        ta = a; tr = r; tw = w; jdo = d;
        tick(1);
        ta = 1'b0; tr = 1'b0; tw = 1'b0;
    endtask

    function automatic logic [37:0] jcmd(input logic [AW-1:0] adr, input bit rd, input bit clr);
        logic [37:0] d;
        d = '0;
        d[AW+16:17] = adr;
        d[34] = rd;
        d[33] = clr;
        return d;
    endfunction

    function automatic logic [37:0] wcmd(input logic [31:0] v);
        return {3'b000, v, 3'b000};
    endfunction

    task automatic cpu_access(input bit we, input logic [AW-1:0] a, input logic [31:0] d, output int n);
        cpu_bus.cpu_req = 1'b1; cpu_bus.cpu_we = we; cpu_bus.cpu_addr = a; cpu_bus.cpu_wdata = d;
        n = 0;
        while (cpu_bus.cpu_waitrequest && n < 20) begin
            tick(1);
            n++;
        end
    endtask

    initial begin
        int n;
        cpu_bus.cpu_req = 1'b0; cpu_bus.cpu_we = 1'b0; cpu_bus.cpu_addr = '0; cpu_bus.cpu_wdata = '0;
        #1 reset = 1'b1;
        tick(2);
        chk("reset ready", 32'(rdy), 32'd0);
        chk("reset error", 32'(err), 32'd0);
        chk("reset MonDReg", mon, 32'd0);
        chk("reset waitrequest", 32'(cpu_bus.cpu_waitrequest), 32'd1);
        chk("reset cpu_rdata", cpu_bus.cpu_rdata, 32'd0);
        reset = 1'b0;

        // load 0x10 with read-after-load
        pulse(1, 0, 0, jcmd(8'h10, 1, 0));
        tick(2);
        chk("load-read ready C+3", 32'(rdy), 32'd0);
        tick(1);
        chk("load-read MonDReg C+4", mon, 32'hDEADBEEF);
        chk("load-read ready C+4", 32'(rdy), 32'd1);
        pulse(0, 1, 0, '0);
        tick(3);
        chk("read-inc MonDReg", mon, 32'h1000_0011);

        // wrap at the top of the address space
        pulse(1, 0, 0, jcmd(8'hFF, 0, 0));
        chk("load-only ready C+1", 32'(rdy), 32'd1);
        pulse(0, 0, 1, wcmd(32'h1));
        tick(2);
        pulse(0, 0, 1, wcmd(32'h2));
        tick(2);
        chk("wrap RAM[FF]", mem[8'hFF], 32'h1);
        chk("wrap RAM[00]", mem[8'h00], 32'h2);
        chk("wrap error", 32'(err), 32'd0);

        // overrun: read pulse arrives while the write is pending
        pulse(0, 0, 1, wcmd(32'h55));
        pulse(0, 1, 0, '0);
        tick(2);
        chk("overrun error", 32'(err), 32'd1);
        chk("overrun write done", mem[8'h01], 32'h55);
        chk("overrun read dropped", mon, 32'h1000_0011);
        pulse(1, 0, 0, jcmd(8'h20, 0, 1));
        chk("error cleared", 32'(err), 32'd0);

        // JTAG read beats a CPU read requested in the same idle cycle
        pulse(1, 0, 0, jcmd(8'h30, 1, 0));
        cpu_access(1'b0, 8'h40, '0, n);
        chk("cpu read latency behind JTAG", 32'(n), 32'd5);
        chk("cpu read data", cpu_bus.cpu_rdata, 32'h1000_0040);
        chk("JTAG read first", mon, 32'h1000_0030);
        tick(1);
        cpu_bus.cpu_req = 1'b0;

        // reset during JCAP
        pulse(1, 0, 0, jcmd(8'h50, 1, 0));
        tick(2);
        #2 reset = 1'b1;
        #1;
        chk("mid reset ram_en", 32'(ram_en), 32'd0);
        chk("mid reset ready", 32'(rdy), 32'd0);
        chk("mid reset MonDReg", mon, 32'd0);
        chk("mid reset waitrequest", 32'(cpu_bus.cpu_waitrequest), 32'd1);
        tick(2);
        reset = 1'b0;
        pulse(0, 1, 0, '0);
        tick(3);
        chk("post reset read jaddr=0", mon, 32'h2);

        // CPU writes into both halves
        cpu_access(1'b1, 8'h05, 32'hA5, n);
        chk("cpu write ack latency", 32'(n), 32'd1);
        tick(1);
        cpu_bus.cpu_req = 1'b0;
        tick(1);
        chk("cpu write low half", mem[8'h05], WP ? 32'h1000_0005 : 32'hA5);
        cpu_access(1'b1, 8'h85, 32'hA5, n);
        chk("cpu write ack latency hi", 32'(n), 32'd1);
        tick(1);
        cpu_bus.cpu_req = 1'b0;
        tick(1);
        chk("cpu write high half", mem[8'h85], 32'hA5);

        // randomized traffic from both masters, with one reset in the middle
        for (int i = 0; i < 2500; i++) begin
            int r;
            r  = $urandom_range(0, 15);
            ta = (r == 0 || r == 3);
            tr = (r == 1 || (r == 3 && $urandom_range(0, 1) == 1));
            tw = (r == 2 || (r == 3 && !tr));
            jdo = {6'($urandom), $urandom};
            if (!cpu_bus.cpu_req || !last_wait) begin
                cpu_bus.cpu_req   = ($urandom_range(0, 2) != 0);
                cpu_bus.cpu_we    = 1'($urandom_range(0, 1));
                cpu_bus.cpu_addr  = AW'($urandom);
                cpu_bus.cpu_wdata = $urandom;
            end
            reset = (i >= 1200 && i < 1202);
            tick(1);
        end
        ta = 1'b0; tr = 1'b0; tw = 1'b0;
        cpu_bus.cpu_req = 1'b0;
        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/debug_ocimem_sequencer.md
# debug_ocimem_sequencer

Sequences the Nios II debug slave's on-chip debug memory (ocimem) accesses, sysclk domain. Turns the JTAG debug commands (address load, read, write, each a one-cycle take_* pulse carrying its payload on jdo) into single-port RAM cycles. Shares that RAM with the CPU's Avalon debug-slave port. Returns read data and status to the JTAG scan chain via MonDReg, monitor_ready and monitor_error.

## Interface
- ADDR_W, 8, ocimem word-address width (2^ADDR_W 32-bit words)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- jdo  in  38  JTAG command payload: jdo[34:3] write data, jdo[ADDR_W+16:17] address, jdo[34] read-after-load flag, jdo[33] error-clear flag (address-load only)
- take_action_ocimem_a  in  1  pulse: load JTAG address
- take_no_action_ocimem_a  in  1  pulse: read at JTAG address, then increment
- take_action_ocimem_b  in  1  pulse: write jdo[34:3] at JTAG address, then increment
- cpu_req, cpu_we  in  1 each  Avalon read/write request from CPU
- cpu_addr  in  ADDR_W, cpu_wdata  in  32
- cpu_rdata  out  32, cpu_waitrequest  out  1
- ram_en, ram_we  out  1 each; ram_addr  out  ADDR_W; ram_wdata  out  32
- ram_rdata  in  32  read data, valid the cycle after ram_en with ram_we=0
- MonDReg  out  32  last JTAG read data
- monitor_ready  out  1  last JTAG command complete
- monitor_error  out  1  sticky overrun flag

## Operation
- Registers:
  - jaddr (ADDR_W bits)
  - one-deep JTAG pending command: valid, op=RD/WR, wdata
- FSM states: IDLE, JOP, JCAP, COP, CCAP. RAM outputs decode from state; ram_en=1 only in JOP/COP.
- JTAG busy = pending valid or state in {JOP, JCAP}.
- Any take_* pulse while busy is an overrun: monitor_error<=1, pulse discarded.
- Two or more take_* pulses in one cycle while not busy:
  - take_action_ocimem_a is accepted.
  - Others are discarded with monitor_error<=1.
- Address load, not busy:
  - jaddr<=jdo address.
  - jdo[33]=1 clears monitor_error (an overrun in the same cycle wins).
  - jdo[34]=0: monitor_ready<=1, no RAM cycle.
  - jdo[34]=1: pending RD queued, monitor_ready<=0.
- Read/write pulse, not busy: pending RD/WR queued (WR captures jdo[34:3]), monitor_ready<=0.
- FSM transitions:
  - IDLE -> JOP when pending valid. JTAG has fixed priority over cpu_req.
  - IDLE -> COP when cpu_req and no pending command.
- JOP:
  - ram_addr=jaddr, pending cleared.
  - WR: ram_we=1, jaddr++, monitor_ready<=1, ->IDLE.
  - RD: ->JCAP.
- JCAP: MonDReg<=ram_rdata, jaddr++, monitor_ready<=1, ->IDLE.
- COP:
  - ram_addr=cpu_addr.
  - Write: ram_we=1, cpu_waitrequest=0, ->IDLE.
  - Read: ->CCAP.
- CCAP: cpu_rdata=ram_rdata, cpu_waitrequest=0, ->IDLE.
- cpu_waitrequest=1 in every other state, including IDLE. The CPU holds its request until waitrequest=0.
- jaddr increments modulo 2^ADDR_W: max wraps to 0 silently, no error.
- Reset, including mid-operation:
  - state=IDLE, pending cleared, jaddr=0, MonDReg=0.
  - monitor_ready=0, monitor_error=0.
  - ram_en=0, ram_we=0 immediately.
  - cpu_waitrequest=1, cpu_rdata=0.
  - An interrupted transaction is lost.

## Timing
- JTAG pulse sampled at edge of cycle C; pending visible C+1; JOP in C+2.
- JTAG write: RAM write in C+2; monitor_ready high from C+3.
- JTAG read: JCAP in C+3; MonDReg and monitor_ready updated, visible C+4.
- A CPU access in progress delays JOP by at most 2 cycles.
- CPU write: waitrequest low 1 cycle after req (COP). CPU read: data and waitrequest low 2 cycles after req (CCAP).
- Back-to-back CPU reads under no JTAG load sustain 1 access per 3 cycles.
- Address load without read completes in 1 cycle.

## Configuration
- DEBUG_OCIMEM_CPU_WP_EN defined:
  - CPU writes with cpu_addr < 2^(ADDR_W-1) (debug ROM half) are dropped: ram_we held 0 in COP.
  - Such writes are still acknowledged normally. JTAG writes are unaffected.
- Undefined: all CPU writes reach the RAM.

## Test plan
- Address load 0x10 with jdo[34]=1, RAM[0x10]=0xDEADBEEF -> MonDReg=0xDEADBEEF and monitor_ready=1 at C+4; jaddr=0x11.
- Address load 0xFF, then two writes 0x1, 0x2 -> RAM[0xFF]=0x1, RAM[0x00]=0x2 (wrap); monitor_error stays 0.
- Write pulse followed by a read pulse 1 cycle later -> monitor_error=1, read dropped, write completes. Address load with jdo[33]=1 -> monitor_error=0.
- cpu_req read and JTAG read pending in same IDLE cycle -> JOP first; CPU rdata returned 2 cycles after JTAG completes; cpu_waitrequest high meanwhile.
- Assert reset during JCAP -> ram_en=0 immediately, monitor_ready=0, MonDReg=0; FSM resumes in IDLE after release.
- With DEBUG_OCIMEM_CPU_WP_EN: CPU write 0xA5 to address 0x05 -> acked, RAM[0x05] unchanged. To address 0x85 -> RAM[0x85]=0xA5.
